line_raster: RTL
================

# line_raster

Bresenham line rasteriser that sits directly upstream of the VGA controller's framebuffer write port. It accepts one line command (two endpoints plus a 9-bit colour) over a valid/ready handshake. It then emits one pixel write per cycle (x, y, 3:3:3 RGB) until the line is complete. Intended as a drawing primitive behind the existing pixel-write mux.

## Interface
- XMAX, default 199: largest visible x coordinate (inclusive); used only when clipping is compiled in.
- YMAX, default 149: largest visible y coordinate (inclusive); used only when clipping is compiled in.
- clk  in  1  clock.
- nrst  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  8 each  start and end points.
- cmd_rgb  in  9  colour: [8:6] R, [5:3] G, [2:0] B.
- px_valid  out  1  pixel write present.
- px_ready  in  1  downstream accepts the pixel.
- px_x, px_y  out  8 each  pixel coordinate.
- px_r, px_g, px_b  out  3 each  pixel colour.
- busy  out  1  high in SETUP and RUN.
- done  out  1  one-cycle pulse after the last pixel is retired.

## Operation
- States: IDLE, SETUP, RUN, DONE.
- IDLE
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch the endpoints and colour, then go to SETUP.
- SETUP (1 cycle)
  - dx=|x1-x0| (9-bit unsigned).
  - dy=-|y1-y0| (10-bit signed).
  - sx=+1 if x1>x0, else -1; sy likewise for y.
  - err=dx+dy (10-bit signed).
  - cur=(x0,y0).
  - Go to RUN.
- RUN: the current pixel is presented on px_*. A step occurs when the pixel retires (see Timing). On a step:
  - If cur==(x1,y1), go to DONE.
  - Else e2=2*err (11-bit signed).
    - If e2>=dy: err+=dy, x+=sx.
    - If e2<=dx: err+=dx, y+=sy.
    - Both updates use the pre-step err.
- Pixels emitted per line = max(dx,|dy|)+1. The first pixel is exactly (x0,y0) and the last is exactly (x1,y1).
- DONE (1 cycle): done=1, then go to IDLE.
- Coordinates never wrap, because the Bresenham walk stays inside the endpoint bounding box.
- A single-point line (x0==x1, y0==y1) emits exactly one pixel.
- A new command is accepted no earlier than the cycle after DONE.
- Reset values: cmd_ready=1, and px_valid, px_x, px_y, px_r, px_g, px_b, busy, done all 0. State is IDLE.
- Reset mid-operation: nrst low at any clk edge drops the state to IDLE. px_valid and busy are 0 the next cycle, done does not pulse, and the line is discarded.

## Timing
- Command accepted at edge N; SETUP in cycle N+1; first px_valid=1 in cycle N+2.
- With px_ready held high: one pixel per cycle, no bubbles. done is asserted in the cycle after the last pixel handshake, and cmd_ready returns the cycle after that.
- A pixel retires on px_valid&&px_ready at a clk edge.
- While px_valid=1 and px_ready=0, px_x, px_y and px_r/px_g/px_b hold stable and no step occurs.
- px_valid never deasserts without a handshake, except on reset or on a clipped pixel.
- All outputs are registered except cmd_ready, which is decoded from the state.

## Configuration
- LINE_RASTER_CLIP_EN
  - Defined: in RUN, a pixel with x>XMAX or y>YMAX is presented with px_valid=0. It steps unconditionally in one cycle without waiting for px_ready, so off-screen pixels are never written. done still pulses after the endpoint is stepped.
  - Undefined: every pixel is emitted, XMAX and YMAX are ignored, and no compare logic is built.

## Test plan
- Horizontal line (10,20)->(15,20), rgb 0x1FF, px_ready=1 → px_valid in cycles N+2..N+7 with x=10..15, y=20, px_r=px_g=px_b=7; done in N+8; cmd_ready in N+9.
- Steep reverse line (5,40)->(2,30) → 11 pixels, y=40 down to 30, x non-increasing from 5 to 2, matching a software Bresenham model; last pixel (2,30).
- Point (7,7)->(7,7) → exactly one pixel (7,7), then done.
- Diagonal (0,0)->(3,3) with px_ready pattern 1,0,1,0,... → outputs held during stall cycles; exactly 4 handshakes with (0,0),(1,1),(2,2),(3,3).
- Clip test (195,10)->(205,10), XMAX=199 → with LINE_RASTER_CLIP_EN: 5 writes x=195..199 and done; without it: 11 writes x=195..205.
- Reset mid-line: nrst=0 on the 3rd pixel of (0,0)->(100,0) → next cycle px_valid=0, busy=0, cmd_ready=1, no done pulse; a new command after reset then draws correctly.

Source files
------------

// File: rtl/line_raster.sv
// line_raster: Bresenham line rasteriser driving the framebuffer pixel-write port.
// Define LINE_RASTER_CLIP_EN to suppress writes of pixels beyond XMAX/YMAX.
module line_raster #(
    parameter int XMAX = 199,
    parameter int YMAX = 149
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_x0,
    input  logic [7:0] cmd_y0,
    input  logic [7:0] cmd_x1,
    input  logic [7:0] cmd_y1,
    input  logic [8:0] cmd_rgb,
    output logic       px_valid,
    input  logic       px_ready,
    output logic [7:0] px_x,
    output logic [7:0] px_y,
    output logic [2:0] px_r,
    output logic [2:0] px_g,
    output logic [2:0] px_b,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [7:0]         x0, y0, x1, y1;
    logic [8:0]         dx;
    logic signed [9:0]  dy, err, err_next;
    logic               sx, sy;
    logic [7:0]         x_diff, y_diff, x_next, y_next;
    logic signed [10:0] e2;
    logic               step_x, step_y, at_end, accept, step;
    logic               vis_first, vis_next;

    assign cmd_ready = (state == IDLE);

    assign x_diff = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
    assign y_diff = (y1 >= y0) ? (y1 - y0) : (y0 - y1);

    // Both axis decisions are taken from the pre-step error term.
    assign e2       = {err, 1'b0};
    assign step_x   = (e2 >= $signed({dy[9], dy}));
    assign step_y   = (e2 <= $signed({2'b00, dx}));
    assign err_next = err + (step_x ? dy : 10'sd0) + (step_y ? $signed({1'b0, dx}) : 10'sd0);
    assign x_next   = step_x ? (sx ? px_x + 8'd1 : px_x - 8'd1) : px_x;
    assign y_next   = step_y ? (sy ? px_y + 8'd1 : px_y - 8'd1) : px_y;
    assign at_end   = (px_x == x1) && (px_y == y1);

`ifdef LINE_RASTER_CLIP_EN
    localparam logic [8:0] XLIM = XMAX[8:0];
    localparam logic [8:0] YLIM = YMAX[8:0];

    assign vis_first = ({1'b0, x0} <= XLIM) && ({1'b0, y0} <= YLIM);
    assign vis_next  = ({1'b0, x_next} <= XLIM) && ({1'b0, y_next} <= YLIM);
`else
    // The limits only matter when clipping is compiled in.
    logic [17:0] unused_clip_limits;
    assign unused_clip_limits = {XMAX[8:0], YMAX[8:0]};
    assign vis_first = 1'b1;
    assign vis_next  = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!nrst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: state_next = RUN;
            RUN: begin
`ifdef LINE_RASTER_CLIP_EN
                // A hidden pixel is never offered downstream, so it steps at once.
                step = px_ready || !px_valid;
`else
                step = px_valid && px_ready;
`endif
                if (step && at_end) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            x0       <= '0;
            y0       <= '0;
            x1       <= '0;
            y1       <= '0;
            dx       <= '0;
            dy       <= '0;
            err      <= '0;
            sx       <= 1'b0;
            sy       <= 1'b0;
            px_valid <= 1'b0;
            px_x     <= '0;
            px_y     <= '0;
            px_r     <= '0;
            px_g     <= '0;
            px_b     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy <= (state_next == SETUP) || (state_next == RUN);
            done <= (state_next == DONE);
            if (accept) begin
                x0                 <= cmd_x0;
                y0                 <= cmd_y0;
                x1                 <= cmd_x1;
                y1                 <= cmd_y1;
                {px_r, px_g, px_b} <= cmd_rgb;
            end
            if (state == SETUP) begin
                dx       <= {1'b0, x_diff};
                dy       <= -$signed({2'b00, y_diff});
                err      <= $signed({2'b00, x_diff}) - $signed({2'b00, y_diff});
                sx       <= (x1 > x0);
                sy       <= (y1 > y0);
                px_x     <= x0;
                px_y     <= y0;
                px_valid <= vis_first;
            end
            if (step) begin
                if (at_end) begin
                    px_valid <= 1'b0;
                end else begin
                    px_x     <= x_next;
                    px_y     <= y_next;
                    err      <= err_next;
                    px_valid <= vis_next;
                end
            end
        end
    end

endmodule
